// File: rtl/uuid_histogram.sv
// Per-UUID saturating occurrence histogram. The table is updated by a
// read-modify-write pipeline with write forwarding; a clear sweep runs after reset.
module uuid_histogram #(
    parameter int CRC_WIDTH = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CRC_WIDTH-1:0] uuid_axis_tdata,
    input  logic                 uuid_axis_tvalid,
    output logic                 uuid_axis_tready,
    input  logic                 hash_err,
    input  logic                 rd_valid,
    input  logic [CRC_WIDTH-1:0] rd_addr,
    output logic                 rd_ready,
    output logic                 rd_data_valid,
    output logic [CNT_WIDTH-1:0] rd_data,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic [CNT_WIDTH-1:0] total_count,
    output logic [CNT_WIDTH-1:0] err_count
);
    localparam int DEPTH = 2**CRC_WIDTH;
    localparam logic [CRC_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_t;

    state_t               state_reg, state_next;
    logic [CRC_WIDTH-1:0] sweep_addr_reg, sweep_addr_next;

    logic [CNT_WIDTH-1:0] mem [DEPTH];
    logic [CNT_WIDTH-1:0] ram_q_reg;
    logic [CRC_WIDTH-1:0] ram_raddr;

    logic                 s1_valid_reg;
    logic [CRC_WIDTH-1:0] s1_addr_reg;
    logic                 rd_data_valid_reg;
    logic [CRC_WIDTH-1:0] rd_addr_reg;
    logic                 fwd_valid_reg;
    logic [CRC_WIDTH-1:0] fwd_addr_reg;
    logic [CNT_WIDTH-1:0] fwd_value_reg;
    logic [CNT_WIDTH-1:0] total_reg;
    logic [CNT_WIDTH-1:0] err_reg;
    logic                 hash_err_prev_reg;

    logic                 is_idle;
    logic                 stream_hs;
    logic                 rd_accept;
    logic                 sweep_we;
    logic                 sweep_last;
    logic                 err_rise;
    logic [CNT_WIDTH-1:0] s1_old;
    logic [CNT_WIDTH-1:0] s1_new;
    logic                 we;
    logic [CRC_WIDTH-1:0] waddr;
    logic [CNT_WIDTH-1:0] wdata;

    always_comb begin
        state_next      = state_reg;
        sweep_addr_next = sweep_addr_reg;
        case (state_reg)
            IDLE: begin
                if (clr_start) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next      = SWEEP;
                sweep_addr_next = '0;
            end
            SWEEP: begin
                sweep_addr_next = sweep_addr_reg + 1'b1;
                if (sweep_addr_reg == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: state_next = DRAIN;
        endcase
    end

    assign is_idle          = (state_reg == IDLE);
    assign rd_ready         = is_idle;
    assign uuid_axis_tready = is_idle && !rd_valid;
    assign clr_busy         = !is_idle;

    assign stream_hs  = uuid_axis_tvalid && uuid_axis_tready;
    assign rd_accept  = rd_valid && is_idle;
    assign sweep_we   = (state_reg == SWEEP);
    assign sweep_last = sweep_we && (sweep_addr_reg == LAST_ADDR);
    assign err_rise   = hash_err && !hash_err_prev_reg;

    // Host reads win the single RAM read port over the stream.
    assign ram_raddr = rd_accept ? rd_addr : uuid_axis_tdata;

    // The RAM returns pre-write data when last cycle wrote the same entry.
    assign s1_old = (fwd_valid_reg && (fwd_addr_reg == s1_addr_reg)) ? fwd_value_reg : ram_q_reg;
    assign s1_new = (s1_old == CNT_MAX) ? s1_old : s1_old + 1'b1;

    // S1 and sweep writes never coincide: no beat can be accepted in DRAIN.
    assign we    = s1_valid_reg || sweep_we;
    assign waddr = sweep_we ? sweep_addr_reg : s1_addr_reg;
    assign wdata = sweep_we ? '0 : s1_new;

    assign rd_data_valid = rd_data_valid_reg;
    assign rd_data       = !rd_data_valid_reg ? '0 :
                           (fwd_valid_reg && (fwd_addr_reg == rd_addr_reg)) ? fwd_value_reg :
                           ram_q_reg;

    assign total_count = total_reg;
    assign err_count   = err_reg;

    always_ff @(posedge clk) begin
        ram_q_reg <= mem[ram_raddr];
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= DRAIN;
            sweep_addr_reg    <= '0;
            s1_valid_reg      <= 1'b0;
            s1_addr_reg       <= '0;
            rd_data_valid_reg <= 1'b0;
            rd_addr_reg       <= '0;
            fwd_valid_reg     <= 1'b0;
            fwd_addr_reg      <= '0;
            fwd_value_reg     <= '0;
            hash_err_prev_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            sweep_addr_reg    <= sweep_addr_next;
            s1_valid_reg      <= stream_hs;
            s1_addr_reg       <= uuid_axis_tdata;
            rd_data_valid_reg <= rd_accept;
            rd_addr_reg       <= rd_addr;
            fwd_valid_reg     <= we;
            fwd_addr_reg      <= waddr;
            fwd_value_reg     <= wdata;
            hash_err_prev_reg <= hash_err;
        end
    end

    // The final sweep cycle's clear takes precedence over any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_reg <= '0;
            err_reg   <= '0;
        end else if (sweep_last) begin
            total_reg <= '0;
            err_reg   <= '0;
        end else begin
            if (stream_hs && (total_reg != CNT_MAX)) begin
                total_reg <= total_reg + 1'b1;
            end
            if (err_rise && (err_reg != CNT_MAX)) begin
                err_reg <= err_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uuid_histogram.sv
// Drives two histogram instances (32-bit and 4-bit counters) with the same stimulus
// and compares both against an unbounded-count reference model with saturation applied.
module tb_uuid_histogram;
    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] uuid_axis_tdata = '0;
    logic       uuid_axis_tvalid = 1'b0;
    logic       hash_err = 1'b0;
    logic       rd_valid = 1'b0;
    logic [7:0] rd_addr = '0;
    logic       clr_start = 1'b0;

    logic        uuid_axis_tready, rd_ready, rd_data_valid, clr_busy;
    logic [31:0] rd_data, total_count, err_count;
    logic        s_tready, s_rd_ready, s_rd_data_valid, s_clr_busy;
    logic [3:0]  s_rd_data, s_total_count, s_err_count;

    uuid_histogram #(.CRC_WIDTH(8), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .uuid_axis_tdata(uuid_axis_tdata), .uuid_axis_tvalid(uuid_axis_tvalid),
        .uuid_axis_tready(uuid_axis_tready), .hash_err(hash_err),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .total_count(total_count), .err_count(err_count)
    );

    uuid_histogram #(.CRC_WIDTH(8), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst),
        .uuid_axis_tdata(uuid_axis_tdata), .uuid_axis_tvalid(uuid_axis_tvalid),
        .uuid_axis_tready(s_tready), .hash_err(hash_err),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(s_rd_ready),
        .rd_data_valid(s_rd_data_valid), .rd_data(s_rd_data),
        .clr_start(clr_start), .clr_busy(s_clr_busy),
        .total_count(s_total_count), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;
    longint table_m [DEPTH];
    longint total_m = 0;
    longint err_m = 0;
    bit     err_prev = 1'b0;
    int     busy_left = 0;

    function automatic logic [31:0] sat(input longint v, input longint m);
        return 32'(v > m ? m : v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready outputs before the edge, update the model at the edge,
    // then check registered outputs of both instances just after it.
    task automatic cycle();
        bit     hs, racc, clr, rise;
        longint exp_rd;
        @(negedge clk);
        check("tready",   {31'd0, uuid_axis_tready}, {31'd0, busy_left == 0 && !rd_valid});
        check("tready_s", {31'd0, s_tready},         {31'd0, busy_left == 0 && !rd_valid});
        check("rd_ready", {31'd0, rd_ready},         {31'd0, busy_left == 0});
        hs     = uuid_axis_tvalid && busy_left == 0 && !rd_valid;
        racc   = rd_valid && busy_left == 0;
        clr    = clr_start && busy_left == 0;
        rise   = hash_err && !err_prev;
        exp_rd = table_m[rd_addr];
        @(posedge clk);
        if (hs) begin
            table_m[uuid_axis_tdata]++;
            total_m++;
        end
        if (rise) err_m++;
        err_prev = hash_err;
        if (clr) begin
            busy_left = DEPTH + 1;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                foreach (table_m[i]) table_m[i] = 0;
                total_m = 0;
                err_m   = 0;
            end
        end
        #1;
        check("clr_busy",   {31'd0, clr_busy},        {31'd0, busy_left != 0});
        check("clr_busy_s", {31'd0, s_clr_busy},      {31'd0, busy_left != 0});
        check("rd_dv",      {31'd0, rd_data_valid},   {31'd0, racc});
        check("rd_dv_s",    {31'd0, s_rd_data_valid}, {31'd0, racc});
        if (racc) begin
            check("rd_data",   rd_data,            sat(exp_rd, 64'hFFFF_FFFF));
            check("rd_data_s", {28'd0, s_rd_data}, sat(exp_rd, 15));
        end
        check("total",   total_count,            sat(total_m, 64'hFFFF_FFFF));
        check("total_s", {28'd0, s_total_count}, sat(total_m, 15));
        check("err",     err_count,              sat(err_m, 64'hFFFF_FFFF));
        check("err_s",   {28'd0, s_err_count},   sat(err_m, 15));
    endtask

    task automatic beat(input logic [7:0] a);
        uuid_axis_tdata  = a;
        uuid_axis_tvalid = 1'b1;
        cycle();
        uuid_axis_tvalid = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a);
        rd_valid = 1'b1;
        rd_addr  = a;
        cycle();
        rd_valid = 1'b0;
    endtask

    initial begin
        int n;
        foreach (table_m[i]) table_m[i] = 0;

        // Reset values while reset is held.
        @(posedge clk); #1;
        check("rst_tready", {31'd0, uuid_axis_tready}, 32'd0);
        check("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
        check("rst_rd_dv", {31'd0, rd_data_valid}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_clr_busy", {31'd0, clr_busy}, 32'd1);
        check("rst_total", total_count, 32'd0);
        check("rst_err", err_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        busy_left = DEPTH + 1;

        // Post-reset sweep length.
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (clr_busy) n++;
            cycle();
        end
        check("reset_busy_len", n, 32'd257);
        host_read(8'd0);
        host_read(8'd17);
        host_read(8'd255);

        // Back-to-back identical UUIDs.
        uuid_axis_tvalid = 1'b1;
        uuid_axis_tdata  = 8'h2A;
        repeat (5) cycle();
        uuid_axis_tvalid = 1'b0;
        cycle();
        check("b2b_total", total_count, 32'd5);
        host_read(8'h2A);

        // Alternating UUIDs.
        beat(8'h01); beat(8'h02); beat(8'h01); beat(8'h02);
        cycle();
        host_read(8'h01);
        host_read(8'h02);

        // Read one cycle after a write to the same entry; stream held valid too.
        beat(8'h10);
        uuid_axis_tvalid = 1'b1;
        rd_valid = 1'b1;
        rd_addr  = 8'h10;
        #1;
        check("collide_tready", {31'd0, uuid_axis_tready}, 32'd0);
        cycle();
        rd_valid = 1'b0;
        uuid_axis_tvalid = 1'b0;
        check("collide_rd", rd_data, 32'd1);

        // Saturation (4-bit instance) and error edges.
        uuid_axis_tdata  = 8'h07;
        uuid_axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            hash_err = (i == 2 || i == 6 || i == 11);
            cycle();
        end
        uuid_axis_tvalid = 1'b0;
        hash_err = 1'b0;
        cycle();
        check("sat_err_s", {28'd0, s_err_count}, 32'd3);
        check("sat_total_s", {28'd0, s_total_count}, 32'd15);
        host_read(8'h07);
        check("sat_entry_s", {28'd0, s_rd_data}, 32'd15);

        // Clear together with a beat; a second request mid-sweep is ignored.
        uuid_axis_tdata  = 8'h33;
        uuid_axis_tvalid = 1'b1;
        clr_start = 1'b1;
        cycle();
        uuid_axis_tvalid = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            clr_start = (i == 100);
            if (clr_busy) n++;
            cycle();
        end
        clr_start = 1'b0;
        check("clear_busy_len", n, 32'd257);
        check("clear_total", total_count, 32'd0);
        host_read(8'h33);
        check("clear_entry", rd_data, 32'd0);

        // Randomized traffic over a small address range to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            uuid_axis_tvalid = ($urandom_range(0, 3) != 0);
            uuid_axis_tdata  = 8'($urandom_range(0, 7));
            rd_valid         = ($urandom_range(0, 3) == 0);
            rd_addr          = 8'($urandom_range(0, 7));
            hash_err         = 1'($urandom_range(0, 1));
            clr_start        = ($urandom_range(0, 299) == 0);
            cycle();
        end
        uuid_axis_tvalid = 1'b0;
        rd_valid  = 1'b0;
        clr_start = 1'b0;
        hash_err  = 1'b0;
        while (busy_left > 0) cycle();
        cycle();
        for (int a = 0; a < 8; a++) host_read(8'(a));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
